alu_seq: RTL and testbench

Parametrised, registered successor to the datapath's 16-bit combinational ALU. It adds a `start`/`busy`/`done` handshake, a signed-overflow flag, add-with-carry using the stored carry, arithmetic shift right, and a multi-cycle unsigned shift-add multiplier. It sits between the register file read ports and the write-back mux, and its flags feed the condition-code register of the control unit.

---
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/result bundle between the register-file read side and the sequential ALU.
interface alu_seq_if #(
  parameter int unsigned W = 16
);

  logic         start;
  logic [W-1:0] R;
  logic [W-1:0] S;
  logic [3:0]   Alu_op;
  logic         busy;
  logic         done;
  logic [W-1:0] Y;
  logic [W-1:0] Y_hi;
  logic         N;
  logic         Z;
  logic         C;
  logic         V;

  modport master (
    output start, R, S, Alu_op,
    input  busy, done, Y, Y_hi, N, Z, C, V
  );

  modport slave (
    input  start, R, S, Alu_op,
    output busy, done, Y, Y_hi, N, Z, C, V
  );

endinterface

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake, NZCV flags and a
// W-cycle unsigned shift-add multiplier.
module alu_seq #(
  parameter int unsigned W = 16
) (
  input  logic      clk,
  input  logic      reset,
  alu_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(W);
  localparam int unsigned EW = W + 1;
  localparam int unsigned PW = 2 * W;

  localparam logic [3:0] OP_PASS_S = 4'b0000;
  localparam logic [3:0] OP_PASS_R = 4'b0001;
  localparam logic [3:0] OP_INC    = 4'b0010;
  localparam logic [3:0] OP_DEC    = 4'b0011;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_SUB    = 4'b0101;
  localparam logic [3:0] OP_LSR    = 4'b0110;
  localparam logic [3:0] OP_LSL    = 4'b0111;
  localparam logic [3:0] OP_AND    = 4'b1000;
  localparam logic [3:0] OP_OR     = 4'b1001;
  localparam logic [3:0] OP_XOR    = 4'b1010;
  localparam logic [3:0] OP_NOT    = 4'b1011;
  localparam logic [3:0] OP_NEG    = 4'b1100;
  localparam logic [3:0] OP_ASR    = 4'b1101;
  localparam logic [3:0] OP_MUL    = 4'b1110;
  localparam logic [3:0] OP_ADC    = 4'b1111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic          single_load_c;
  logic          mul_start_c;
  logic          mul_last_c;

  logic [CW-1:0] cnt;
  logic [PW-1:0] acc;
  logic [PW-1:0] mcand;
  logic [W-1:0]  mplier;
  logic [PW-1:0] acc_step_c;

  logic [EW-1:0] ext_c;
  logic [W-1:0]  res_y_c;
  logic          res_c_c;
  logic          res_v_c;

  logic [W-1:0]  y_q;
  logic [W-1:0]  y_hi_q;
  logic          n_q;
  logic          z_q;
  logic          c_q;
  logic          v_q;
  logic          busy_q;
  logic          done_q;

  assign bus.Y    = y_q;
  assign bus.Y_hi = y_hi_q;
  assign bus.N    = n_q;
  assign bus.Z    = z_q;
  assign bus.C    = c_q;
  assign bus.V    = v_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and load strobes; start is only looked at while idle.
  always_comb begin
    state_nxt     = state;
    single_load_c = 1'b0;
    mul_start_c   = 1'b0;
    mul_last_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.Alu_op == OP_MUL) begin
            mul_start_c = 1'b1;
            state_nxt   = ST_MUL;
          end else begin
            single_load_c = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (cnt == CW'(W - 1)) begin
          mul_last_c = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Single-cycle result and carry/overflow, arithmetic done at W+1 bits.
  always_comb begin
    ext_c   = '0;
    res_y_c = '0;
    res_c_c = 1'b0;
    res_v_c = 1'b0;
    case (bus.Alu_op)
      OP_PASS_S: res_y_c = bus.S;
      OP_PASS_R: res_y_c = bus.R;
      OP_INC: begin
        ext_c   = {1'b0, bus.S} + EW'(1);
        res_y_c = ext_c[W-1:0];
        res_c_c = ext_c[W];
        res_v_c = ~bus.S[W-1] & res_y_c[W-1];
      end
      OP_DEC: begin
        ext_c   = {1'b0, bus.S} - EW'(1);
        res_y_c = ext_c[W-1:0];
        res_c_c = ext_c[W];
        res_v_c = bus.S[W-1] & ~res_y_c[W-1];
      end
      OP_ADD: begin
        ext_c   = {1'b0, bus.R} + {1'b0, bus.S};
        res_y_c = ext_c[W-1:0];
        res_c_c = ext_c[W];
        res_v_c = (bus.R[W-1] == bus.S[W-1]) && (res_y_c[W-1] != bus.R[W-1]);
      end
      OP_SUB: begin
        ext_c   = {1'b0, bus.R} - {1'b0, bus.S};
        res_y_c = ext_c[W-1:0];
        res_c_c = ext_c[W];
        res_v_c = (bus.R[W-1] != bus.S[W-1]) && (res_y_c[W-1] != bus.R[W-1]);
      end
      OP_LSR: begin
        res_y_c = bus.S >> 1;
        res_c_c = bus.S[0];
      end
      OP_LSL: begin
        res_y_c = bus.S << 1;
        res_c_c = bus.S[W-1];
      end
      OP_AND: res_y_c = bus.R & bus.S;
      OP_OR:  res_y_c = bus.R | bus.S;
      OP_XOR: res_y_c = bus.R ^ bus.S;
      OP_NOT: res_y_c = ~bus.S;
      OP_NEG: begin
        ext_c   = EW'(0) - {1'b0, bus.S};
        res_y_c = ext_c[W-1:0];
        res_c_c = ext_c[W];
        res_v_c = bus.S[W-1] & res_y_c[W-1];
      end
      OP_ASR: begin
        res_y_c = {bus.S[W-1], bus.S[W-1:1]};
        res_c_c = bus.S[0];
      end
      OP_ADC: begin
        ext_c   = {1'b0, bus.R} + {1'b0, bus.S} + EW'(c_q);
        res_y_c = ext_c[W-1:0];
        res_c_c = ext_c[W];
        res_v_c = (bus.R[W-1] == bus.S[W-1]) && (res_y_c[W-1] != bus.R[W-1]);
      end
      default: res_y_c = '0;
    endcase
  end

  // One shift-add multiplier step: add the shifted multiplicand when the current bit is set.
  assign acc_step_c = acc + (mplier[0] ? mcand : '0);

  // Multiplier working registers and iteration counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (mul_start_c) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= PW'(bus.R);
      mplier <= bus.S;
    end else if (state == ST_MUL) begin
      cnt    <= mul_last_c ? '0 : cnt + CW'(1);
      acc    <= acc_step_c;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // Result, flag and handshake registers; results only change on a done edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q    <= '0;
      y_hi_q <= '0;
      n_q    <= 1'b0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt == ST_MUL);
      done_q <= single_load_c | mul_last_c;
      if (single_load_c) begin
        y_q    <= res_y_c;
        y_hi_q <= '0;
        n_q    <= res_y_c[W-1];
        z_q    <= (res_y_c == '0);
        c_q    <= res_c_c;
        v_q    <= res_v_c;
      end else if (mul_last_c) begin
        y_q    <= acc_step_c[W-1:0];
        y_hi_q <= acc_step_c[PW-1:W];
        n_q    <= acc_step_c[PW-1];
        z_q    <= (acc_step_c == '0);
        c_q    <= (acc_step_c[PW-1:W] != '0);
        v_q    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned W    = 16;
  localparam longint      MOD  = 64'sd1 <<< W;
  localparam longint      HALF = MOD / 2;
  localparam longint      MASK = MOD - 1;

  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_LSR = 4'h6;
  localparam logic [3:0] OP_LSL = 4'h7;
  localparam logic [3:0] OP_ASR = 4'hD;
  localparam logic [3:0] OP_MUL = 4'hE;
  localparam logic [3:0] OP_ADC = 4'hF;

  logic clk = 1'b0;
  logic reset;

  alu_seq_if #(.W(W)) bus ();

  alu_seq #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: what Y/Y_hi/flags should hold right now.
  longint m_y, m_yhi;
  bit     m_n, m_z, m_c, m_v;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint sgn(input longint x);
    return (x >= HALF) ? x - MOD : x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_held(input string tag);
    check({tag, "_y"}, 64'(bus.Y), 64'(m_y));
    check({tag, "_yhi"}, 64'(bus.Y_hi), 64'(m_yhi));
    check({tag, "_nzcv"}, 64'({bus.N, bus.Z, bus.C, bus.V}), 64'({m_n, m_z, m_c, m_v}));
  endtask

  // Behavioural model of one operation; updates the reference state.
  task automatic model_op(input logic [3:0] op, input longint r, input longint s);
    longint y, yhi, full, sres;
    bit c, arith;
    y = 0; yhi = 0; full = 0; sres = 0; c = 0; arith = 0;
    case (op)
      4'h0: y = s;
      4'h1: y = r;
      4'h2: begin full = s + 1; c = (full >= MOD); sres = sgn(s) + 1; arith = 1; end
      4'h3: begin full = s - 1; c = (s == 0); sres = sgn(s) - 1; arith = 1; end
      4'h4: begin full = r + s; c = (full >= MOD); sres = sgn(r) + sgn(s); arith = 1; end
      4'h5: begin full = r - s; c = (r < s); sres = sgn(r) - sgn(s); arith = 1; end
      4'h6: begin y = s / 2; c = (s % 2) != 0; end
      4'h7: begin y = (s * 2) & MASK; c = (s >= HALF); end
      4'h8: y = r & s;
      4'h9: y = r | s;
      4'hA: y = r ^ s;
      4'hB: y = MASK - s;
      4'hC: begin full = -s; c = (s != 0); sres = -sgn(s); arith = 1; end
      4'hD: begin y = (sgn(s) >>> 1) & MASK; c = (s % 2) != 0; end
      4'hE: begin full = r * s; y = full & MASK; yhi = full / MOD; end
      default: begin
        full = r + s + longint'(m_c); c = (full >= MOD);
        sres = sgn(r) + sgn(s) + longint'(m_c); arith = 1;
      end
    endcase
    if (arith) y = full & MASK;
    m_y = y;
    m_yhi = yhi;
    if (op == 4'hE) begin
      m_n = (yhi >= HALF); m_z = (full == 0); m_c = (yhi != 0); m_v = 0;
    end else begin
      m_n = (y >= HALF); m_z = (y == 0); m_c = c;
      m_v = arith && ((sres > HALF - 1) || (sres < -HALF));
    end
  endtask

  task automatic do_single(input logic [3:0] op, input logic [W-1:0] r, input logic [W-1:0] s);
    string tag;
    tag = $sformatf("op%0d", op);
    bus.start = 1'b1; bus.Alu_op = op; bus.R = r; bus.S = s;
    step();
    model_op(op, longint'(r), longint'(s));
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check_held(tag);
    bus.start = 1'b0;
  endtask

  task automatic do_idle();
    bus.start = 1'b0; bus.Alu_op = 4'($urandom); bus.R = W'($urandom); bus.S = W'($urandom);
    step();
    check("idle_done", 64'(bus.done), 64'd0);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check_held("idle");
  endtask

  // Issue a multiply, throw junk (including ignored starts) at the inputs while busy.
  task automatic do_mul(input logic [W-1:0] r, input logic [W-1:0] s);
    int lat;
    bus.start = 1'b1; bus.Alu_op = OP_MUL; bus.R = r; bus.S = s;
    step();
    check("mul_busy0", 64'(bus.busy), 64'd1);
    check("mul_done0", 64'(bus.done), 64'd0);
    lat = 0;
    for (int i = 1; i <= int'(W) + 4; i++) begin
      bus.start = 1'($urandom); bus.Alu_op = 4'($urandom);
      bus.R = W'($urandom); bus.S = W'($urandom);
      if (i == 4) begin
        bus.start = 1'b1; bus.Alu_op = OP_ADD;
      end
      step();
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
      check("mul_busy", 64'(bus.busy), 64'd1);
      check("mul_hold_y", 64'(bus.Y), 64'(m_y));
    end
    bus.start = 1'b0;
    if (lat == 0) lat = int'(W) + 5;
    check("mul_latency", 64'(lat), 64'(W));
    model_op(OP_MUL, longint'(r), longint'(s));
    check("mul_busy_end", 64'(bus.busy), 64'd0);
    check_held("mul");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    m_y = 0; m_yhi = 0; m_n = 0; m_z = 0; m_c = 0; m_v = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.Alu_op = 4'h0; bus.R = '0; bus.S = '0;

    // Reset with active random requests: everything must stay cleared.
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'b1; bus.Alu_op = 4'($urandom); bus.R = W'($urandom); bus.S = W'($urandom);
      step();
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check_held("rst");
    end
    reset = 1'b0;
    do_idle();

    // Directed vectors.
    do_single(OP_ADD, 16'h7FFF, 16'h0001);
    check("add_y", 64'(bus.Y), 64'h8000);
    check("add_nzcv", 64'({bus.N, bus.Z, bus.C, bus.V}), 64'b1001);
    do_single(OP_SUB, 16'h0003, 16'h0005);
    check("sub_y", 64'(bus.Y), 64'hFFFE);
    check("sub_nzcv", 64'({bus.N, bus.Z, bus.C, bus.V}), 64'b1010);
    do_single(OP_ADD, 16'hFFFF, 16'h0001);
    check("addc_y", 64'(bus.Y), 64'h0000);
    check("addc_nzcv", 64'({bus.N, bus.Z, bus.C, bus.V}), 64'b0110);
    do_single(OP_ADC, 16'h0000, 16'h0000);
    check("adc_y", 64'(bus.Y), 64'h0001);
    check("adc_nzcv", 64'({bus.N, bus.Z, bus.C, bus.V}), 64'b0000);
    do_single(OP_LSL, 16'h0000, 16'h8001);
    check("lsl_y", 64'(bus.Y), 64'h0002);
    check("lsl_c", 64'(bus.C), 64'd1);
    do_single(OP_ASR, 16'h0000, 16'h8002);
    check("asr_y", 64'(bus.Y), 64'hC001);
    check("asr_c", 64'(bus.C), 64'd0);
    do_single(OP_LSR, 16'h0000, 16'h8002);
    check("lsr_y", 64'(bus.Y), 64'h4001);
    check("lsr_c", 64'(bus.C), 64'd0);
    do_idle();

    do_mul(16'h1234, 16'h5678);
    check("mul1_y", 64'(bus.Y), 64'h0060);
    check("mul1_yhi", 64'(bus.Y_hi), 64'h0626);
    check("mul1_c", 64'(bus.C), 64'd1);
    do_mul(16'hFFFF, 16'hFFFF);
    check("mul2_y", 64'(bus.Y), 64'h0001);
    check("mul2_yhi", 64'(bus.Y_hi), 64'hFFFE);
    check("mul2_n", 64'(bus.N), 64'd1);

    // Reset in the middle of a multiply.
    bus.start = 1'b1; bus.Alu_op = OP_MUL; bus.R = 16'h1234; bus.S = 16'h5678;
    step();
    bus.start = 1'b0;
    for (int i = 1; i < 7; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_y = 0; m_yhi = 0; m_n = 0; m_z = 0; m_c = 0; m_v = 0;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check_held("midrst");
    for (int i = 0; i < int'(W); i++) do_idle();
    do_mul(16'h0003, 16'h0005);
    check("mul3_y", 64'(bus.Y), 64'h000F);
    check("mul3_yhi", 64'(bus.Y_hi), 64'h0000);
    check("mul3_c", 64'(bus.C), 64'd0);

    // Random mix: back-to-back singles, ADC chains, multiplies and idle gaps.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      op = 4'($urandom);
      if ($urandom_range(0, 7) == 0) do_idle();
      else if (op == OP_MUL) do_mul(W'($urandom), W'($urandom));
      else do_single(op, W'($urandom), W'($urandom));
    end
    do_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
